// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared types and defaults for the serial transmit link
// State encodings are shared with the receiver side so both ends agree on framing.
package piso_serializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - word load handshake and serial line bundle
// slave is the serializer side; master is the producer / line observer side.
interface piso_serializer_if
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output ser_out,
    output ser_valid,
    output ser_last,
    output busy
  );

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_last,
    input  busy
  );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// rtl/piso_serializer_bit_counter.sv - modulo-WIDTH bit position counter
// clr wins over en; tc flags the final bit position of a word.
module piso_serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc    = (count_q == CW'(WIDTH - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with frame qualifiers
// A word is loaded on handshake and its bits appear one per clock starting the next cycle.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  piso_serializer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    count;
  logic             last_bit;
  logic             load_ready;
  logic             accept;
  logic             in_shift;

  assign in_shift   = (state_q == ST_SHIFT);
  assign load_ready = !in_shift || last_bit;
  assign accept     = bus.load_valid && load_ready;

  piso_serializer_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (accept),
    .en    (in_shift),
    .count (count),
    .tc    (last_bit)
  );

  // The first bit goes straight to the output flop, so the shift register
  // only ever holds the bits still to be sent.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    ser_out_d = 1'b0;
    if (accept) begin
      state_d = ST_SHIFT;
      if (MSB_FIRST) begin
        ser_out_d = bus.load_data[WIDTH-1];
        shreg_d   = bus.load_data << 1;
      end else begin
        ser_out_d = bus.load_data[0];
        shreg_d   = bus.load_data >> 1;
      end
    end else if (in_shift && !last_bit) begin
      if (MSB_FIRST) begin
        ser_out_d = shreg_q[WIDTH-1];
        shreg_d   = shreg_q << 1;
      end else begin
        ser_out_d = shreg_q[0];
        shreg_d   = shreg_q >> 1;
      end
    end else if (in_shift) begin
      state_d = ST_IDLE;
      shreg_d = '0;
    end
  end

  // The registered last strobe looks one bit ahead: it fires when the
  // counter is about to step onto the final position.
  always_comb begin
    busy_d      = (state_d == ST_SHIFT);
    ser_valid_d = busy_d;
    ser_last_d  = busy_d && !accept && in_shift && (count == CW'(WIDTH - 2));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_last   = ser_last_q;
  assign bus.busy       = busy_q;

endmodule
